ram_rd_arb: RTL and testbench
=============================

RAM_RD_ARB -- requirements
Module: ram_rd_arb

Interface
REQ-001 Parameter DW, default 8: data width, identical to the attached two-port RAM.
REQ-002 Parameter MD, default 1024: memory depth.
REQ-003 Parameter AW, default $clog2(MD): address width.
REQ-004 Parameter READ_REGISTERED, default 1: SHALL equal the attached RAM's setting; read latency LAT = 1 + READ_REGISTERED cycles.
REQ-005 clk  in  1  single clock, rising edge; also drives the RAM read clock.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 clk_en  in  1  clock enable; also drives the RAM read clock enable.
REQ-008 req0 / req1  in  1  read request from requester 0 / 1.
REQ-009 adr0 / adr1  in  AW  read address from requester 0 / 1.
REQ-010 ack0 / ack1  out  1  request accepted in this cycle.
REQ-011 ram_rd  out  1  RAM read enable.
REQ-012 ram_adr  out  AW  RAM read address.
REQ-013 ram_dat  in  DW  RAM read data.
REQ-014 rdat  out  DW  returned read data, shared by both requesters; equals ram_dat.
REQ-015 rvld0 / rvld1  out  1  rdat valid for requester 0 / 1.
REQ-016 busy  out  1  at least one read is in flight.

Function
REQ-017 All state SHALL advance only on rising clk edges with clk_en=1; with clk_en=0 all registers hold.
REQ-018 Requester handshake: hold reqN and adrN stable until ackN is sampled high. One read is accepted per ackN pulse.
REQ-019 Grant is combinational from req0, req1, clk_en and the last-grant pointer; at most one of ack0/ack1 is high, and only when clk_en=1.
REQ-020 Single request: reqN=1 with the other request 0 -> ackN=1 in the same cycle.
REQ-021 Both requests: grant the requester not named by the last-grant pointer (round-robin).
REQ-022 Last-grant pointer: 1 bit; updates to the granted id on each accepted grant with clk_en=1; unchanged when there is no grant.
REQ-023 ram_rd = ack0 | ack1.
REQ-024 ram_adr: adr of the granted requester; adr0 when there is no grant.
REQ-025 Tag pipeline: LAT stages, each holding {valid, id}.
  - Stage 1 loads {ram_rd, granted id}.
  - Later stages shift when clk_en=1.
REQ-026 Return: rvldN = clk_en & last-stage valid & (last-stage id == N); asserted for exactly one enabled cycle per accepted read, LAT enabled cycles after its ack.
REQ-027 Throughput: one grant per enabled cycle, back-to-back, no bubbles; returns arrive in grant order.
REQ-028 busy = OR of all tag-stage valid bits.
REQ-029 Reset with reads in flight: all pending reads are discarded; no rvld for them after reset.

Reset
REQ-030 When rst_n=0 at a clk edge (independent of clk_en):
  - all tag-stage valid bits clear to 0;
  - last-grant pointer sets to 1, so requester 0 wins the first contention.
REQ-031 While rst_n=0: ack0, ack1, ram_rd, rvld0, rvld1, busy = 0; ram_adr = adr0.

Verification
REQ-032 Bench SHALL model the RAM with mem[i]=i+8'h10, READ_REGISTERED=1, clk_en=1 unless a scenario states otherwise.
REQ-033 Single read: req0=1, adr0=5 for one cycle -> ack0=1 and ram_rd=1 in that cycle; rvld0=1 with rdat=8'h15 two cycles later; rvld1 stays 0.
REQ-034 Contention after reset: req0 and req1 held with adr0=1, adr1=2 for 4 cycles ->
  - acks alternate ack0, ack1, ack0, ack1;
  - returns are rvld0/8'h11, rvld1/8'h12, rvld0/8'h11, rvld1/8'h12 on consecutive cycles starting 2 cycles after the first ack.
REQ-035 Clock enable stall: grant req1 at adr 3, then drive clk_en=0 for 3 cycles -> ack, rvld and pipeline frozen during the stall; rvld1 with rdat=8'h13 appears on the second enabled cycle after the grant.
REQ-036 Reset mid-flight: grant req0 at adr 7, then drive rst_n=0 in the next cycle -> no rvld0 ever returns for that read; busy=0 after reset; the next contention grants requester 0 first.
REQ-037 Latency parameter: READ_REGISTERED=0, req1 at adr 9 -> rvld1 with rdat=8'h19 one cycle after ack1; busy=1 only during that cycle.

Source files
------------

// File: rtl/ram_rd_arb.sv
`default_nettype none
// ============================================================================
// Module  : ram_rd_arb
// Brief   : Two-requester round-robin read arbiter for a two-port RAM read port,
//           with a tag pipeline that routes returned data to the requester.
// Revision: 1.0 - initial release
// ============================================================================
module ram_rd_arb #(
    parameter int DW              = 8,
    parameter int MD              = 1024,
    parameter int AW              = $clog2(MD),
    parameter int READ_REGISTERED = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    output logic          ack0,
    output logic          ack1,
    output logic          ram_rd,
    output logic [AW-1:0] ram_adr,
    input  logic [DW-1:0] ram_dat,
    output logic [DW-1:0] rdat,
    output logic          rvld0,
    output logic          rvld1,
    output logic          busy
);

    localparam int c_LAT = 1 + READ_REGISTERED;

    logic             r_last;
    logic [c_LAT-1:0] r_vld;
    logic [c_LAT-1:0] r_id;

    logic w_grant_ok;
    logic w_ack0;
    logic w_ack1;

    // Holding reset low forces every handshake output inactive.
    assign w_grant_ok = clk_en & rst_n;
    assign w_ack0     = w_grant_ok & req0 & (~req1 | r_last);
    assign w_ack1     = w_grant_ok & req1 & (~req0 | ~r_last);

    assign ack0    = w_ack0;
    assign ack1    = w_ack1;
    assign ram_rd  = w_ack0 | w_ack1;
    assign ram_adr = w_ack1 ? adr1 : adr0;
    assign rdat    = ram_dat;

    assign rvld0 = w_grant_ok & r_vld[c_LAT-1] & ~r_id[c_LAT-1];
    assign rvld1 = w_grant_ok & r_vld[c_LAT-1] &  r_id[c_LAT-1];
    assign busy  = rst_n & (|r_vld);

    // Tag stages track the RAM read latency so each return carries its owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_id   <= '0;
            r_last <= 1'b1;
        end else if (clk_en) begin
            r_vld[0] <= w_ack0 | w_ack1;
            r_id[0]  <= w_ack1;
            for (int i = 1; i < c_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
            if (w_ack0 | w_ack1) begin
                r_last <= w_ack1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_rd_arb
// Brief   : Directed self-checking bench for ram_rd_arb (registered and
//           unregistered RAM read latency variants).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_rd_arb;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic       req0, req1;
    logic [9:0] adr0, adr1;

    logic       ack0_a, ack1_a, ram_rd_a, rvld0_a, rvld1_a, busy_a;
    logic [9:0] ram_adr_a;
    logic [7:0] ram_dat_a, rdat_a;
    logic       ack0_b, ack1_b, ram_rd_b, rvld0_b, rvld1_b, busy_b;
    logic [9:0] ram_adr_b;
    logic [7:0] ram_dat_b, rdat_b;

    logic [7:0] q1_a, q2_a, q1_b;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_rd_arb #(.DW(8), .MD(1024), .READ_REGISTERED(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .req0(req0), .req1(req1), .adr0(adr0), .adr1(adr1),
        .ack0(ack0_a), .ack1(ack1_a), .ram_rd(ram_rd_a), .ram_adr(ram_adr_a),
        .ram_dat(ram_dat_a), .rdat(rdat_a),
        .rvld0(rvld0_a), .rvld1(rvld1_a), .busy(busy_a)
    );

    ram_rd_arb #(.DW(8), .MD(1024), .READ_REGISTERED(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .req0(req0), .req1(req1), .adr0(adr0), .adr1(adr1),
        .ack0(ack0_b), .ack1(ack1_b), .ram_rd(ram_rd_b), .ram_adr(ram_adr_b),
        .ram_dat(ram_dat_b), .rdat(rdat_b),
        .rvld0(rvld0_b), .rvld1(rvld1_b), .busy(busy_b)
    );

    // RAM models: mem[i] = i + 8'h10
    always @(posedge clk) begin
        if (clk_en) begin
            if (ram_rd_a) q1_a <= ram_adr_a[7:0] + 8'h10;
            q2_a <= q1_a;
            if (ram_rd_b) q1_b <= ram_adr_b[7:0] + 8'h10;
        end
    end
    assign ram_dat_a = q2_a;
    assign ram_dat_b = q1_b;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clk_en = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b0; clk_en = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; clk_en = 1'b1; req0 = 1'b1; req1 = 1'b1; adr0 = 10'd4; adr1 = 10'd6;
        #1;
        checks++; if (ack0_a !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0_a); end
        checks++; if (ack1_a !== 1'b0) begin failures++; $display("FAIL reset_ack1 got=%b exp=0", ack1_a); end
        checks++; if (ram_rd_a !== 1'b0) begin failures++; $display("FAIL reset_ram_rd got=%b exp=0", ram_rd_a); end
        checks++; if (ram_adr_a !== 10'd4) begin failures++; $display("FAIL reset_ram_adr got=%0d exp=4", ram_adr_a); end
        @(negedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if ({rvld0_a, rvld1_a} !== 2'b00) begin failures++; $display("FAIL reset_rvld got=%b exp=00", {rvld0_a, rvld1_a}); end
        @(negedge clk);
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_after got=%b exp=0", busy_a); end
    endtask

    task automatic test_single();
        @(negedge clk);
        req0 = 1'b1; adr0 = 10'd5; req1 = 1'b0;
        #1;
        checks++; if (ack0_a !== 1'b1) begin failures++; $display("FAIL single_ack0 got=%b exp=1", ack0_a); end
        checks++; if (ack1_a !== 1'b0) begin failures++; $display("FAIL single_ack1 got=%b exp=0", ack1_a); end
        checks++; if (ram_rd_a !== 1'b1) begin failures++; $display("FAIL single_ram_rd got=%b exp=1", ram_rd_a); end
        checks++; if (ram_adr_a !== 10'd5) begin failures++; $display("FAIL single_ram_adr got=%0d exp=5", ram_adr_a); end
        @(negedge clk);
        req0 = 1'b0;
        #1;
        checks++; if (rvld0_a !== 1'b0) begin failures++; $display("FAIL single_rvld0_early got=%b exp=0", rvld0_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy_a); end
        @(negedge clk);
        #1;
        checks++; if (rvld0_a !== 1'b1) begin failures++; $display("FAIL single_rvld0 got=%b exp=1", rvld0_a); end
        checks++; if (rdat_a !== 8'h15) begin failures++; $display("FAIL single_rdat got=%h exp=15", rdat_a); end
        checks++; if (rvld1_a !== 1'b0) begin failures++; $display("FAIL single_rvld1 got=%b exp=0", rvld1_a); end
        @(negedge clk);
        #1;
        checks++; if (rvld0_a !== 1'b0) begin failures++; $display("FAIL single_rvld0_once got=%b exp=0", rvld0_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", busy_a); end
    endtask

    task automatic test_contention();
        logic [5:0] e_ack0, e_ack1, e_rv0, e_rv1;
        logic [9:0] e_adr;
        e_ack0 = 6'b000101; e_ack1 = 6'b001010;
        e_rv0  = 6'b010100; e_rv1  = 6'b101000;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clk);
            req0 = (k < 4); req1 = (k < 4); adr0 = 10'd1; adr1 = 10'd2;
            #1;
            e_adr = e_ack1[k] ? 10'd2 : 10'd1;
            checks++; if ({ack0_a, ack1_a} !== {e_ack0[k], e_ack1[k]}) begin failures++; $display("FAIL cont_ack k=%0d got=%b exp=%b", k, {ack0_a, ack1_a}, {e_ack0[k], e_ack1[k]}); end
            checks++; if (ram_adr_a !== e_adr) begin failures++; $display("FAIL cont_ram_adr k=%0d got=%0d exp=%0d", k, ram_adr_a, e_adr); end
            checks++; if ({rvld0_a, rvld1_a} !== {e_rv0[k], e_rv1[k]}) begin failures++; $display("FAIL cont_rvld k=%0d got=%b exp=%b", k, {rvld0_a, rvld1_a}, {e_rv0[k], e_rv1[k]}); end
            if (k >= 2) begin
                checks++; if (rdat_a !== (e_rv0[k] ? 8'h11 : 8'h12)) begin failures++; $display("FAIL cont_rdat k=%0d got=%h exp=%h", k, rdat_a, (e_rv0[k] ? 8'h11 : 8'h12)); end
            end
        end
        idle(1);
    endtask

    task automatic test_clk_en_stall();
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b1; adr1 = 10'd3; clk_en = 1'b1;
        #1;
        checks++; if (ack1_a !== 1'b1) begin failures++; $display("FAIL stall_ack1 got=%b exp=1", ack1_a); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clk_en = 1'b0; req1 = 1'b0; req0 = 1'b1; adr0 = 10'd8;
            #1;
            checks++; if ({ack0_a, ack1_a, ram_rd_a} !== 3'b000) begin failures++; $display("FAIL stall_ack k=%0d got=%b exp=000", k, {ack0_a, ack1_a, ram_rd_a}); end
            checks++; if ({rvld0_a, rvld1_a} !== 2'b00) begin failures++; $display("FAIL stall_rvld k=%0d got=%b exp=00", k, {rvld0_a, rvld1_a}); end
            checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL stall_busy k=%0d got=%b exp=1", k, busy_a); end
        end
        @(negedge clk);
        clk_en = 1'b1; req0 = 1'b0;
        #1;
        checks++; if (rvld1_a !== 1'b0) begin failures++; $display("FAIL stall_rvld1_first got=%b exp=0", rvld1_a); end
        @(negedge clk);
        #1;
        checks++; if (rvld1_a !== 1'b1) begin failures++; $display("FAIL stall_rvld1 got=%b exp=1", rvld1_a); end
        checks++; if (rdat_a !== 8'h13) begin failures++; $display("FAIL stall_rdat got=%h exp=13", rdat_a); end
        @(negedge clk);
        #1;
        checks++; if ({rvld0_a, rvld1_a, busy_a} !== 3'b000) begin failures++; $display("FAIL stall_drain got=%b exp=000", {rvld0_a, rvld1_a, busy_a}); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        req0 = 1'b1; adr0 = 10'd7; req1 = 1'b0; clk_en = 1'b1;
        #1;
        checks++; if (ack0_a !== 1'b1) begin failures++; $display("FAIL mid_ack0 got=%b exp=1", ack0_a); end
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_busy_in_reset got=%b exp=0", busy_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            checks++; if ({rvld0_a, busy_a} !== 2'b00) begin failures++; $display("FAIL mid_discard k=%0d got=%b exp=00", k, {rvld0_a, busy_a}); end
        end
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; adr0 = 10'd1; adr1 = 10'd2;
        #1;
        checks++; if ({ack0_a, ack1_a} !== 2'b10) begin failures++; $display("FAIL mid_first_grant got=%b exp=10", {ack0_a, ack1_a}); end
        idle(4);
    endtask

    task automatic test_latency();
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b1; adr1 = 10'd9; clk_en = 1'b1;
        #1;
        checks++; if (ack1_b !== 1'b1) begin failures++; $display("FAIL lat0_ack1 got=%b exp=1", ack1_b); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL lat0_busy_before got=%b exp=0", busy_b); end
        @(negedge clk);
        req1 = 1'b0;
        #1;
        checks++; if (rvld1_b !== 1'b1) begin failures++; $display("FAIL lat0_rvld1 got=%b exp=1", rvld1_b); end
        checks++; if (rdat_b !== 8'h19) begin failures++; $display("FAIL lat0_rdat got=%h exp=19", rdat_b); end
        checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL lat0_busy got=%b exp=1", busy_b); end
        @(negedge clk);
        #1;
        checks++; if ({rvld1_b, busy_b} !== 2'b00) begin failures++; $display("FAIL lat0_after got=%b exp=00", {rvld1_b, busy_b}); end
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; req0 = 1'b0; req1 = 1'b0; adr0 = '0; adr1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_clk_en_stall();
        test_reset_midflight();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
